drink_selector: RTL
===================

DRINK_SELECTOR -- requirements
Module: drink_selector

Interface
REQ-001 The block SHALL have parameter LOOKUP_TIMEOUT, default 20, giving the maximum cycles in LOOKUP waiting for db_done.
REQ-002 The block SHALL have parameter ERR_HOLD, default 8, giving the cycles held in ERROR before returning to IDLE.
REQ-003 Clocking and reset SHALL be: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-004 Ports SHALL be as follows:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_valid  input  1  one-cycle strobe; btn_drink is valid.
- btn_drink  input  3  drink index 0-7.
- btn_option  input  1  one-cycle strobe; toggles the extra bit (ice for drinks 0-3, sugar for drinks 4-7).
- btn_confirm  input  1  one-cycle strobe; starts the lookup.
- btn_cancel  input  1  one-cycle strobe; aborts the selection.
- db_done  input  1  match indication from the database stage.
- db_enable  output  1  enable to the database stage.
- db_code  output  4  code presented to the database stage.
- sel_valid  output  1  a selection is offered downstream.
- sel_code  output  4  code offered with sel_valid.
- sel_ready  input  1  downstream accepts the selection.
- busy  output  1  high in every state except IDLE.
- error  output  1  high in ERROR.

Function
REQ-005 The FSM SHALL have states IDLE, SELECTED, LOOKUP, ISSUE and ERROR; all outputs SHALL be registered.
REQ-006 The code register SHALL be {opt, drink[2:0]} and SHALL drive both db_code and sel_code.
REQ-007 IDLE: on btn_valid, the FSM SHALL load drink from btn_drink, clear opt, and go to SELECTED; all other inputs SHALL be ignored.
REQ-008 SELECTED: the FSM SHALL respond to inputs as follows:
- btn_valid reloads drink and clears opt.
- btn_option toggles opt.
- btn_confirm clears the timer and goes to LOOKUP.
- btn_cancel goes to IDLE.
REQ-009 When several strobes arrive in the same cycle in SELECTED, priority SHALL be cancel > confirm > btn_valid > btn_option.
REQ-010 LOOKUP: db_enable SHALL be 1 and db_code SHALL stay constant; the timer SHALL increment every cycle.
REQ-011 LOOKUP: db_done high SHALL move the FSM to ISSUE on the next edge.
REQ-012 LOOKUP: if the timer reaches LOOKUP_TIMEOUT with no db_done, the FSM SHALL go to ERROR.
REQ-013 If db_done and timeout occur in the same cycle, db_done SHALL win.
REQ-014 LOOKUP: btn_cancel SHALL return the FSM to IDLE; other buttons SHALL be ignored.
REQ-015 db_enable SHALL be 0 outside LOOKUP, and db_code SHALL hold its last value.
REQ-016 ISSUE: sel_valid SHALL be 1, with sel_code stable until a cycle where sel_valid and sel_ready are both high.
REQ-017 After that transfer cycle, the FSM SHALL return to IDLE and sel_valid SHALL be 0 on the next cycle; exactly one transfer SHALL occur per selection.
REQ-018 ISSUE SHALL ignore btn_cancel, because the selection is committed.
REQ-019 ERROR: error SHALL be 1 for exactly ERR_HOLD cycles, after which the FSM returns to IDLE; all inputs SHALL be ignored.
REQ-020 The timer SHALL be $clog2(max(LOOKUP_TIMEOUT, ERR_HOLD)+1) bits wide, SHALL saturate, and SHALL never wrap.

Reset
REQ-021 While rst_n = 0, the block SHALL hold state = IDLE, code = 0 and timer = 0, and every output SHALL be 0.
REQ-022 A reset asserted mid-operation SHALL clear db_enable, sel_valid and error immediately, without waiting for a clock edge.

Structure
REQ-023 Package drink_pkg SHALL hold:
- the state enum;
- drink constants WATER=0, COLA=1, ORANGE=2, LEMON=3, TEA=4, COFFEE=5, CAPPUCCINO=6, LATTE=7;
- OPT_BIT=3;
- the default parameter values.
REQ-024 The block SHALL instantiate one sub-module, sel_timer: a clearable saturating up-counter shared by the LOOKUP timeout and the ERROR hold.

Verification
REQ-025 Select 5, option, confirm, db_done after 6 cycles, sel_ready=1 -> db_code=4'hD in LOOKUP; sel_code=4'hD; one transfer; busy=0 next cycle.
REQ-026 Select 2, confirm, db_done held 0 -> error rises after 20 LOOKUP cycles, stays high 8 cycles, then IDLE; sel_valid never asserted.
REQ-027 Select 3, select 6, option twice -> confirm yields db_code=4'h6.
REQ-028 btn_cancel on LOOKUP cycle 3 -> IDLE next cycle, db_enable=0, no sel_valid; btn_confirm and btn_cancel together in SELECTED -> IDLE.
REQ-029 sel_ready held low 10 cycles in ISSUE -> sel_valid and sel_code stable throughout; transfer on the first ready cycle; db_done and timeout in the same cycle -> ISSUE.
REQ-030 rst_n driven low between edges mid-LOOKUP -> all outputs 0 before the next clk edge; state IDLE after release.

Source files
------------

// File: rtl/drink_pkg.sv
// Shared types and constants for the drink selector: FSM states, drink indices and defaults.
package drink_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECTED = 3'd1,
        LOOKUP   = 3'd2,
        ISSUE    = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam logic [2:0] WATER      = 3'd0;
    localparam logic [2:0] COLA       = 3'd1;
    localparam logic [2:0] ORANGE     = 3'd2;
    localparam logic [2:0] LEMON      = 3'd3;
    localparam logic [2:0] TEA        = 3'd4;
    localparam logic [2:0] COFFEE     = 3'd5;
    localparam logic [2:0] CAPPUCCINO = 3'd6;
    localparam logic [2:0] LATTE      = 3'd7;

    // Extra-option bit: ice for drinks 0-3, sugar for drinks 4-7.
    localparam int unsigned OPT_BIT = 3;
    localparam int unsigned CODE_W  = 4;

    localparam int unsigned DEF_LOOKUP_TIMEOUT = 20;
    localparam int unsigned DEF_ERR_HOLD       = 8;

endpackage

// File: rtl/sel_timer.sv
// Clearable saturating up-counter, shared by the lookup timeout and the error hold.
module sel_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/drink_selector.sv
// Drink selection FSM: pick a drink and option, look it up in the database stage,
// then hand the code downstream with a valid/ready transfer.
module drink_selector
    import drink_pkg::*;
#(
    parameter int unsigned LOOKUP_TIMEOUT = DEF_LOOKUP_TIMEOUT,
    parameter int unsigned ERR_HOLD       = DEF_ERR_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_valid,
    input  logic [2:0] btn_drink,
    input  logic       btn_option,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    input  logic       db_done,
    output logic       db_enable,
    output logic [3:0] db_code,
    output logic       sel_valid,
    output logic [3:0] sel_code,
    input  logic       sel_ready,
    output logic       busy,
    output logic       error
);

    localparam int unsigned TMR_MAX = (LOOKUP_TIMEOUT > ERR_HOLD) ? LOOKUP_TIMEOUT : ERR_HOLD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    // Leave on the edge where the count would reach the limit, so the state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(LOOKUP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(ERR_HOLD - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   code_nxt;
    logic                tmr_clr;
    logic                tmr_en;
    logic [TMR_W-1:0]    timer;

    sel_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .count (timer)
    );

    // Next-state, code and timer control.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_valid) begin
                    state_nxt = SELECTED;
                    code_nxt  = {1'b0, btn_drink};
                end
            end
            SELECTED: begin
                if (btn_cancel) begin
                    state_nxt = IDLE;
                end else if (btn_confirm) begin
                    state_nxt = LOOKUP;
                    tmr_clr   = 1'b1;
                end else if (btn_valid) begin
                    code_nxt = {1'b0, btn_drink};
                end else if (btn_option) begin
                    code_nxt[OPT_BIT] = ~code[OPT_BIT];
                end
            end
            LOOKUP: begin
                tmr_en = 1'b1;
                if (btn_cancel) begin
                    state_nxt = IDLE;
                end else if (db_done) begin
                    state_nxt = ISSUE;
                end else if (timer >= TMO_LAST) begin
                    state_nxt = ERROR;
                    tmr_clr   = 1'b1;
                end
            end
            ISSUE: begin
                if (sel_valid && sel_ready) begin
                    state_nxt = IDLE;
                end
            end
            ERROR: begin
                tmr_en = 1'b1;
                if (timer >= HOLD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, code and registered outputs, all decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= '0;
            db_enable <= 1'b0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            db_enable <= (state_nxt == LOOKUP);
            sel_valid <= (state_nxt == ISSUE);
            busy      <= (state_nxt != IDLE);
            error     <= (state_nxt == ERROR);
        end
    end

    assign db_code  = code;
    assign sel_code = code;

endmodule
